tick_sync_receiver: RTL and testbench
=====================================

TICK_SYNC_RECEIVER -- requirements
Module: tick_sync_receiver

Interface
REQ-001 Parameter CHANNELS, default 4: number of independent tick channels, legal range 1..32.
REQ-002 Parameter SYNC_STAGES, default 2: synchroniser flops per channel, minimum 2.
REQ-003 Parameter COUNT_WIDTH, default 3: width of each per-channel pending-tick counter, legal range 1..8.
REQ-004 clock, input, 1: the single clock; all state is updated on its rising edge.
REQ-005 reset, input, 1: asynchronous, active-high reset.
REQ-006 inToggle, input, CHANNELS: per-channel toggle from a foreign domain; every level change is one tick.
REQ-007 tickReady, input, CHANNELS: per-channel consumer ready.
REQ-008 clearOverflow, input, CHANNELS: per-channel clear for the sticky overflow flag.
REQ-009 outTick, output, CHANNELS: per-channel delivery strobe, one tick per cycle high.
REQ-010 outAck, output, CHANNELS: per-channel last-accepted toggle level, returned to the source.
REQ-011 pendingCount, output, CHANNELS*COUNT_WIDTH: channel n occupies bits [n*COUNT_WIDTH +: COUNT_WIDTH].
REQ-012 overflow, output, CHANNELS: per-channel sticky flag for lost ticks.

Function
REQ-013 Each channel shall pass inToggle through SYNC_STAGES flops, then one history flop; an edge is sync-output XOR history.
REQ-014 The history flop shall load the sync output every cycle, and outAck shall equal the history flop.
REQ-015 outTick[n] shall be combinational: (pendingCount[n] != 0) AND tickReady[n].
REQ-016 Counter update per cycle: +1 on edge only; -1 on delivery (outTick high) only; unchanged on both or neither.
REQ-017 Latency: with tickReady high, an inToggle change set up before rising edge k shall raise outTick after edge k+SYNC_STAGES.
REQ-018 Saturation: when the count is at 2^COUNT_WIDTH-1 with an edge and no delivery, the count shall hold and the tick is lost.
REQ-019 At the count maximum, an edge together with a delivery shall leave the count unchanged and lose no tick.
REQ-020 A count of 0 with tickReady high shall produce no outTick and no underflow.
REQ-021 Channels shall be fully independent; simultaneous edges on all channels shall each be counted.
REQ-022 Sources shall toggle no faster than once per SYNC_STAGES+1 cycles; faster toggling is outside specification.

Reset
REQ-023 Reset shall asynchronously clear every synchroniser flop, history flop, counter and overflow flag to 0.
REQ-024 During reset, outTick, outAck, pendingCount and overflow shall all read 0.
REQ-025 Assertion of reset mid-operation shall discard all pending ticks immediately, without waiting for a clock edge.
REQ-026 A channel whose inToggle is 1 at reset release shall deliver exactly one tick; sources shall reset their toggle to 0.

Configuration
REQ-027 Macro TICK_SYNC_RECEIVER_OVERFLOW_EN shall select overflow-flag support.
REQ-028 With TICK_SYNC_RECEIVER_OVERFLOW_EN defined: overflow[n] sets on each REQ-018 event and holds until clearOverflow[n].
REQ-029 With the macro defined and set and clear in the same cycle, set shall win.
REQ-030 Without the macro, overflow shall be tied to 0, clearOverflow ignored, and lost ticks dropped silently.

Verification
REQ-031 SYNC_STAGES=2, tickReady=1; toggle ch0 0->1 before edge 0 -> outTick[0] high for exactly the cycle after edge 2; outAck[0]=1 after edge 2.
REQ-032 tickReady[1]=0; 3 toggles on ch1 spaced 4 cycles -> pendingCount ch1 reaches 3; raise tickReady -> 3 consecutive outTick pulses, count reaches 0.
REQ-033 COUNT_WIDTH=3, tickReady=0; 9 toggles on ch2 -> count holds 7; overflow[2]=1 when macro defined, 0 when undefined; clearOverflow[2] pulse -> 0.
REQ-034 Count=2, tickReady=1, edge arriving in the same cycle -> count stays 2, outTick high that cycle.
REQ-035 Reset asserted mid-cycle with count=5 -> pendingCount, outTick and outAck are 0 before the next clock edge; no tick after release with inToggle=0.
REQ-036 Toggle all 4 channels in the same cycle -> all 4 outTick bits pulse in the same cycle.

Source files
------------

// File: rtl/tick_sync_receiver.sv
// Multi-channel toggle-to-tick receiver: synchronises foreign-domain toggles and
// queues ticks per channel. Define TICK_SYNC_RECEIVER_OVERFLOW_EN for sticky overflow flags.

module tick_sync_lane #(
  parameter int SYNC_STAGES = 2,
  parameter int COUNT_WIDTH = 3
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   toggle,
  input  logic                   ready,
  input  logic                   clear,
  output logic                   tick,
  output logic                   ack,
  output logic [COUNT_WIDTH-1:0] count,
  output logic                   overflow
);
  logic [SYNC_STAGES-1:0] sync;
  logic                   hist;
  logic                   tick_edge;
  logic                   full;

  assign tick_edge = sync[SYNC_STAGES-1] ^ hist;
  assign full      = &count;
  assign tick      = (count != '0) & ready;
  assign ack       = hist;

  // Edge and delivery together cancel, so a full counter still accepts that edge.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync  <= '0;
      hist  <= 1'b0;
      count <= '0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], toggle};
      hist <= sync[SYNC_STAGES-1];
      if (tick_edge && !tick && !full)
        count <= count + 1'b1;
      else if (!tick_edge && tick)
        count <= count - 1'b1;
    end
  end

`ifdef TICK_SYNC_RECEIVER_OVERFLOW_EN
  logic lost;
  logic ovf_q;

  assign lost     = tick_edge & ~tick & full;
  assign overflow = ovf_q;

  // Set beats clear when both happen in one cycle.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)      ovf_q <= 1'b0;
    else if (lost)  ovf_q <= 1'b1;
    else if (clear) ovf_q <= 1'b0;
  end
`else
  logic unused_clear;
  assign unused_clear = clear;
  assign overflow     = 1'b0;
`endif
endmodule

module tick_sync_receiver #(
  parameter int CHANNELS    = 4,
  parameter int SYNC_STAGES = 2,
  parameter int COUNT_WIDTH = 3
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic [CHANNELS-1:0]             inToggle,
  input  logic [CHANNELS-1:0]             tickReady,
  input  logic [CHANNELS-1:0]             clearOverflow,
  output logic [CHANNELS-1:0]             outTick,
  output logic [CHANNELS-1:0]             outAck,
  output logic [CHANNELS*COUNT_WIDTH-1:0] pendingCount,
  output logic [CHANNELS-1:0]             overflow
);
  for (genvar n = 0; n < CHANNELS; n++) begin : g_lane
    tick_sync_lane #(
      .SYNC_STAGES(SYNC_STAGES),
      .COUNT_WIDTH(COUNT_WIDTH)
    ) u_lane (
      .clock   (clock),
      .reset   (reset),
      .toggle  (inToggle[n]),
      .ready   (tickReady[n]),
      .clear   (clearOverflow[n]),
      .tick    (outTick[n]),
      .ack     (outAck[n]),
      .count   (pendingCount[n*COUNT_WIDTH +: COUNT_WIDTH]),
      .overflow(overflow[n])
    );
  end
endmodule

// File: tb/tb_tick_sync_receiver.sv
// Scoreboard bench for tick_sync_receiver: arrival-time queues and integer counts
// model each channel; a negedge monitor compares every cycle and consumes ticks.

module tb_tick_sync_receiver;
  localparam int CH   = 4;
  localparam int S    = 2;
  localparam int CW   = 3;
  localparam int MAXC = (1 << CW) - 1;
`ifdef TICK_SYNC_RECEIVER_OVERFLOW_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic [CH-1:0]     inToggle = '0;
  logic [CH-1:0]     tickReady = '0;
  logic [CH-1:0]     clearOverflow = '0;
  logic [CH-1:0]     outTick, outAck, overflow;
  logic [CH*CW-1:0]  pendingCount;

  tick_sync_receiver #(.CHANNELS(CH), .SYNC_STAGES(S), .COUNT_WIDTH(CW)) dut (
    .clock(clock), .reset(reset), .inToggle(inToggle), .tickReady(tickReady),
    .clearOverflow(clearOverflow), .outTick(outTick), .outAck(outAck),
    .pendingCount(pendingCount), .overflow(overflow)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int cnt [CH];
  bit ack_m [CH];
  bit ovf_m [CH];
  int last [CH];
  int arr_q [CH][$];
  int tick_q [CH][$];
  logic [CH-1:0] lvl = '0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  task automatic model_clear();
    for (int n = 0; n < CH; n++) begin
      cnt[n] = 0; ack_m[n] = 1'b0; ovf_m[n] = 1'b0;
      arr_q[n].delete(); tick_q[n].delete();
    end
  endtask

  // Reference: a toggle issued before edge k lands in the counter at edge k+S.
  initial begin
    model_clear();
    forever begin
      @(posedge clock);
      cyc++;
      if (reset) model_clear();
      else begin
        for (int n = 0; n < CH; n++) begin
          bit e, d, lost;
          e = (arr_q[n].size() > 0) && (arr_q[n][0] == cyc);
          if (e) begin void'(arr_q[n].pop_front()); ack_m[n] = ~ack_m[n]; end
          d = (cnt[n] != 0) && tickReady[n];
          lost = e && !d && (cnt[n] == MAXC);
          if (e && !d && !lost) cnt[n]++;
          else if (!e && d) cnt[n]--;
          if (e && !lost) tick_q[n].push_back(cyc);
          if (OVF_EN && lost) ovf_m[n] = 1'b1;
          else if (OVF_EN && clearOverflow[n]) ovf_m[n] = 1'b0;
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clock);
      if (!reset) begin
        for (int n = 0; n < CH; n++) begin
          check($sformatf("count%0d", n), int'(pendingCount[n*CW +: CW]), cnt[n]);
          check($sformatf("ack%0d", n), int'(outAck[n]), int'(ack_m[n]));
          check($sformatf("ovf%0d", n), int'(overflow[n]), int'(ovf_m[n]));
          check($sformatf("tick%0d", n), int'(outTick[n]), int'((cnt[n] != 0) && tickReady[n]));
          if (outTick[n]) begin
            check($sformatf("tick_sb%0d", n), int'(tick_q[n].size() > 0), 1);
            if (tick_q[n].size() > 0) void'(tick_q[n].pop_front());
          end
        end
      end
    end
  end

  task automatic step(input int k);
    repeat (k) @(posedge clock);
    #1;
  endtask

  task automatic toggle(input int n);
    lvl[n] = ~lvl[n];
    inToggle[n] = lvl[n];
    arr_q[n].push_back(cyc + 1 + S);
    last[n] = cyc;
  endtask

  task automatic release_reset();
    reset = 1'b0;
    for (int n = 0; n < CH; n++)
      if (lvl[n]) begin arr_q[n].push_back(cyc + 1 + S); last[n] = cyc; end
  endtask

  initial begin
    for (int n = 0; n < CH; n++) last[n] = -100;
    tickReady = '1;
    @(negedge clock);
    check("rst_count", int'(pendingCount), 0);
    check("rst_tick", int'(outTick), 0);
    check("rst_ack", int'(outAck), 0);
    check("rst_ovf", int'(overflow), 0);
    step(2);
    release_reset();
    step(3);

    // Single-tick latency on ch0
    toggle(0);
    repeat (2) @(posedge clock);
    @(negedge clock);
    check("lat_early", int'(outTick[0]), 0);
    @(negedge clock);
    check("lat_tick", int'(outTick[0]), 1);
    check("lat_ack", int'(outAck[0]), 1);
    @(negedge clock);
    check("lat_once", int'(outTick[0]), 0);
    step(2);

    // Backlog of 3 on ch1, then drain
    tickReady[1] = 1'b0;
    repeat (3) begin toggle(1); step(4); end
    @(negedge clock);
    check("backlog3", int'(pendingCount[1*CW +: CW]), 3);
    step(1);
    tickReady[1] = 1'b1;
    step(4);
    check("drained1", int'(pendingCount[1*CW +: CW]), 0);

    // Saturation and overflow on ch2
    tickReady[2] = 1'b0;
    repeat (9) begin toggle(2); step(4); end
    check("sat_count", int'(pendingCount[2*CW +: CW]), MAXC);
    check("sat_ovf", int'(overflow[2]), int'(OVF_EN));
    clearOverflow[2] = 1'b1;
    step(1);
    clearOverflow[2] = 1'b0;
    check("ovf_clr", int'(overflow[2]), 0);
    tickReady[2] = 1'b1;
    step(10);

    // Edge and delivery in one cycle at count 2 on ch3
    tickReady[3] = 1'b0;
    toggle(3); step(4);
    toggle(3); step(4);
    toggle(3); step(2);
    tickReady[3] = 1'b1;
    step(1);
    check("both_count", int'(pendingCount[3*CW +: CW]), 2);
    check("both_tick", int'(outTick[3]), 1);
    step(6);

    // All channels at once
    tickReady = '1;
    for (int n = 0; n < CH; n++) toggle(n);
    step(S + 1);
    check("all_tick", int'(outTick), (1 << CH) - 1);
    step(4);

    // Randomised traffic
    for (int i = 0; i < 1600; i++) begin
      for (int n = 0; n < CH; n++)
        tickReady[n] = (i < 800) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 2) == 0);
      clearOverflow = ($urandom_range(0, 9) == 0) ? CH'($urandom) : '0;
      for (int n = 0; n < CH; n++)
        if ((cyc - last[n] >= S + 1) && ($urandom_range(0, 2) == 0)) toggle(n);
      step(1);
    end
    clearOverflow = '0;

    // Mid-cycle reset with a backlog of 5 on ch0
    tickReady = '0;
    step(6);
    for (int n = 0; n < CH; n++) tickReady[n] = 1'b1;
    step(12);
    tickReady[0] = 1'b0;
    repeat (5) begin toggle(0); step(4); end
    step(2);
    check("pre_rst5", int'(pendingCount[0 +: CW]), 5);
    tickReady[0] = 1'b1;
    #2;
    reset = 1'b1;
    inToggle = '0;
    lvl = '0;
    model_clear();
    #1;
    check("arst_count", int'(pendingCount), 0);
    check("arst_tick", int'(outTick), 0);
    check("arst_ack", int'(outAck), 0);
    step(2);
    release_reset();
    step(10);
    check("no_tick_after", int'(tick_q[0].size()), 0);

    // Toggle already high at reset release yields exactly one tick
    reset = 1'b1;
    model_clear();
    inToggle[1] = 1'b1;
    lvl[1] = 1'b1;
    step(2);
    release_reset();
    step(12);
    for (int n = 0; n < CH; n++) begin
      check($sformatf("sb_empty%0d", n), tick_q[n].size(), 0);
      check($sformatf("arr_empty%0d", n), arr_q[n].size(), 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
